// File: rtl/vga_pkg.sv
// vga_pkg: axis state encoding, default 640x480 timing, colour-bar table
package vga_pkg;
  typedef enum logic [1:0] {ACT, FRONT, SYNC, BACK} axis_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int DEF_CW = 10;
  localparam int DEF_RGB_W = 12;
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};
endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: framebuffer/DAC bus; patSel present with VGA_TEST_PATTERN_EN
interface vga_timing_ctrl_if import vga_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int RGB_W = DEF_RGB_W
);
  logic pixelEn;
  logic [RGB_W-1:0] pixIn;
  logic [CW-1:0] reqX;
  logic [CW-1:0] reqY;
  logic pixReq;
  logic hSync;
  logic vSync;
  logic displayEn;
  logic [RGB_W-1:0] rgbOut;
  logic frameStart;
`ifdef VGA_TEST_PATTERN_EN
  logic patSel;
  modport master(input pixelEn, pixIn, patSel,
                 output reqX, reqY, pixReq, hSync, vSync, displayEn, rgbOut, frameStart);
  modport slave(output pixelEn, pixIn, patSel,
                input reqX, reqY, pixReq, hSync, vSync, displayEn, rgbOut, frameStart);
`else
  modport master(input pixelEn, pixIn,
                 output reqX, reqY, pixReq, hSync, vSync, displayEn, rgbOut, frameStart);
  modport slave(output pixelEn, pixIn,
                input reqX, reqY, pixReq, hSync, vSync, displayEn, rgbOut, frameStart);
`endif
endinterface

// File: rtl/vga_axis_seq.sv
// vga_axis_seq: one raster axis, ACT->FRONT->SYNC->BACK with position counter
module vga_axis_seq import vga_pkg::*; #(
  parameter int ACT_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN = DEF_H_FRONT,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BACK_LEN = DEF_H_BACK,
  parameter int CW = DEF_CW
) (
  input  logic          inClock,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] pos,
  output logic          last,
  output logic          active,
  output logic          sync
);
  axis_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_m1;
  // final count index of the current state
  always_comb len_m1 = state == ACT ? CW'(ACT_LEN - 1) :
                       state == FRONT ? CW'(FRONT_LEN - 1) :
                       state == SYNC ? CW'(SYNC_LEN - 1) : CW'(BACK_LEN - 1);
  assign last = state == BACK && cnt == len_m1;
  assign active = state == ACT;
  assign sync = state == SYNC;
  // advance state, in-state count and position on each step; BACK wraps to ACT
  always_ff @(posedge inClock or posedge reset)
    if (reset) begin
      state <= ACT;
      cnt <= '0;
      pos <= '0;
    end else if (step) begin
      cnt <= cnt == len_m1 ? '0 : cnt + 1'b1;
      state <= cnt == len_m1 ? axis_t'(state + 2'd1) : state;
      pos <= last ? '0 : pos + 1'b1;
    end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing with pixel prefetch; VGA_TEST_PATTERN_EN adds colour bars
module vga_timing_ctrl import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter int CW = DEF_CW,
  parameter int RGB_W = DEF_RGB_W
) (
  input logic inClock,
  input logic reset,
  vga_timing_ctrl_if.master bus
);
  logic h_last, h_active, h_sync;
  logic v_last, v_active, v_sync;
  logic [RGB_W-1:0] pix;
  vga_axis_seq #(.ACT_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC),
                 .BACK_LEN(H_BACK), .CW(CW)) u_h (
    .inClock(inClock), .reset(reset), .step(bus.pixelEn), .pos(bus.reqX),
    .last(h_last), .active(h_active), .sync(h_sync));
  vga_axis_seq #(.ACT_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC),
                 .BACK_LEN(V_BACK), .CW(CW)) u_v (
    .inClock(inClock), .reset(reset), .step(bus.pixelEn & h_last), .pos(bus.reqY),
    .last(v_last), .active(v_active), .sync(v_sync));
`ifdef VGA_TEST_PATTERN_EN
  assign pix = bus.patSel ? RGB_W'(BARS[3'(bus.reqX / CW'(H_ACTIVE / 8))]) : bus.pixIn;
`else
  assign pix = bus.pixIn;
`endif
  assign bus.pixReq = h_active & v_active;
  // register the decode of the position being consumed by this strobe
  always_ff @(posedge inClock or posedge reset)
    if (reset) begin
      bus.hSync <= 1'b1;
      bus.vSync <= 1'b1;
      bus.displayEn <= 1'b0;
      bus.rgbOut <= '0;
      bus.frameStart <= 1'b0;
    end else begin
      bus.frameStart <= bus.pixelEn && bus.reqX == '0 && bus.reqY == '0;
      if (bus.pixelEn) begin
        bus.displayEn <= bus.pixReq;
        bus.hSync <= !h_sync;
        bus.vSync <= !v_sync;
        bus.rgbOut <= bus.pixReq ? pix : '0;
      end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized raster checks against an arithmetic position model
module tb_vga_timing_ctrl;
  logic inClock = 0;
  logic reset = 1;
  always #5 inClock = ~inClock;

  vga_timing_ctrl_if #(.CW(10), .RGB_W(12)) bd();
  vga_timing_ctrl_if #(.CW(10), .RGB_W(12)) bs();

  vga_timing_ctrl dut (.inClock(inClock), .reset(reset), .bus(bd));
  vga_timing_ctrl #(.H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut_s (
    .inClock(inClock), .reset(reset), .bus(bs));

  int ha[2] = '{640, 16};
  int hf[2] = '{16, 2};
  int hsw[2] = '{96, 3};
  int hb[2] = '{48, 2};
  int va[2] = '{480, 6};
  int vf[2] = '{10, 1};
  int vsw[2] = '{2, 2};
  int vb[2] = '{33, 1};
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
  int mx[2] = '{0, 0};
  int my[2] = '{0, 0};
  bit pat = 0;
  int errors = 0;
  int checks = 0;
  logic [3:0] ob_ctl, e_ctl;
  logic [11:0] ob_rgb, e_rgb;
  int ob_x, ob_y;

  task automatic strobe(input int s, input logic [11:0] pix);
    int x, y, ht, vt;
    logic de, hs, vs, fs, pr;
    logic [11:0] rgb;
    logic [9:0] ox, oy;
    x = mx[s];
    y = my[s];
    ht = ha[s] + hf[s] + hsw[s] + hb[s];
    vt = va[s] + vf[s] + vsw[s] + vb[s];
    de = x < ha[s] && y < va[s];
    hs = !(x >= ha[s] + hf[s] && x < ha[s] + hf[s] + hsw[s]);
    vs = !(y >= va[s] + vf[s] && y < va[s] + vf[s] + vsw[s]);
    fs = x == 0 && y == 0;
    rgb = !de ? 12'h000 : (pat && s == 0) ? bars[x / (ha[s] / 8)] : pix;
    @(negedge inClock);
    if (s == 1) begin bs.pixelEn = 1; bs.pixIn = pix; end
    else begin bd.pixelEn = 1; bd.pixIn = pix; end
    @(posedge inClock);
    #1;
    bs.pixelEn = 0;
    bd.pixelEn = 0;
    mx[s] = x + 1 == ht ? 0 : x + 1;
    if (x + 1 == ht) my[s] = y + 1 == vt ? 0 : y + 1;
    pr = mx[s] < ha[s] && my[s] < va[s];
    ob_ctl = s == 1 ? {bs.displayEn, bs.hSync, bs.vSync, bs.frameStart}
                    : {bd.displayEn, bd.hSync, bd.vSync, bd.frameStart};
    ob_rgb = s == 1 ? bs.rgbOut : bd.rgbOut;
    ox = s == 1 ? bs.reqX : bd.reqX;
    oy = s == 1 ? bs.reqY : bd.reqY;
    ob_x = x;
    ob_y = y;
    checks++;
    if (ob_ctl !== {de, hs, vs, fs}) begin
      errors++;
      $display("FAIL ctrl s=%0d (%0d,%0d) de/hs/vs/fs got %b want %b", s, x, y, ob_ctl, {de, hs, vs, fs});
    end
    checks++;
    if (ob_rgb !== rgb) begin
      errors++;
      $display("FAIL rgbOut s=%0d (%0d,%0d) got %h want %h", s, x, y, ob_rgb, rgb);
    end
    checks++;
    if ({ox, oy} !== {10'(mx[s]), 10'(my[s])}) begin
      errors++;
      $display("FAIL req s=%0d got (%0d,%0d) want (%0d,%0d)", s, ox, oy, mx[s], my[s]);
    end
    checks++;
    if ((s == 1 ? bs.pixReq : bd.pixReq) !== pr) begin
      errors++;
      $display("FAIL pixReq s=%0d at (%0d,%0d) want %b", s, mx[s], my[s], pr);
    end
    e_ctl = {de, hs, vs, fs};
    e_rgb = rgb;
    @(posedge inClock);
    #1;
    checks++;
    if ((s == 1 ? bs.frameStart : bd.frameStart) !== 1'b0) begin
      errors++;
      $display("FAIL frameStart_clear s=%0d got 1 want 0", s);
    end
    repeat ($urandom_range(0, 2)) @(posedge inClock);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({bd.displayEn, bd.hSync, bd.vSync, bd.frameStart, bd.rgbOut, bd.reqX, bd.reqY} !== {4'b0110, 32'd0}) begin
      errors++;
      $display("FAIL %s_dut got %b%b%b%b rgb=%h req=(%0d,%0d) want 0110 000 (0,0)", tag,
               bd.displayEn, bd.hSync, bd.vSync, bd.frameStart, bd.rgbOut, bd.reqX, bd.reqY);
    end
    checks++;
    if ({bs.displayEn, bs.hSync, bs.vSync, bs.frameStart, bs.rgbOut, bs.reqX, bs.reqY} !== {4'b0110, 32'd0}) begin
      errors++;
      $display("FAIL %s_small got %b%b%b%b rgb=%h req=(%0d,%0d) want 0110 000 (0,0)", tag,
               bs.displayEn, bs.hSync, bs.vSync, bs.frameStart, bs.rgbOut, bs.reqX, bs.reqY);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge inClock);
    #1;
    check_reset_vals("reset");
    @(negedge inClock);
    reset = 0;
    mx = '{0, 0};
    my = '{0, 0};
  endtask

  task automatic test_first_pixel;
    strobe(0, 12'($urandom));
    checks++;
    if (ob_ctl !== 4'b1111 || bd.reqX !== 10'd1 || bd.reqY !== 10'd0) begin
      errors++;
      $display("FAIL first_pixel got ctl=%b req=(%0d,%0d) want 1111 (1,0)", ob_ctl, bd.reqX, bd.reqY);
    end
  endtask

  task automatic test_line;
    int de_cnt, hs_cnt, hs_first;
    de_cnt = 1;
    hs_cnt = 0;
    hs_first = -1;
    while (mx[0] != 0) begin
      strobe(0, 12'($urandom));
      if (ob_ctl[3]) de_cnt++;
      if (!ob_ctl[2]) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = ob_x;
      end
    end
    checks++;
    if (de_cnt != 640) begin errors++; $display("FAIL line_de got %0d want 640", de_cnt); end
    checks++;
    if (hs_cnt != 96 || hs_first != 656) begin
      errors++;
      $display("FAIL line_hsync got %0d from x=%0d want 96 from x=656", hs_cnt, hs_first);
    end
    checks++;
    if (bd.reqX !== 10'd0 || bd.reqY !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap got (%0d,%0d) want (0,1)", bd.reqX, bd.reqY);
    end
  endtask

  task automatic test_const_colour;
    int abc_cnt, blank_bad;
    abc_cnt = 0;
    blank_bad = 0;
    do begin
      strobe(0, 12'hABC);
      if (ob_rgb === 12'hABC) abc_cnt++;
      if (ob_x >= 640 && ob_rgb !== 12'h000) blank_bad++;
    end while (mx[0] != 0);
    checks++;
    if (abc_cnt != 640 || blank_bad != 0) begin
      errors++;
      $display("FAIL const_colour got abc=%0d blank_nonzero=%0d want 640 0", abc_cnt, blank_bad);
    end
  endtask

  task automatic test_pause;
    while (mx[0] != 300) strobe(0, 12'($urandom));
    bd.pixIn = 12'h5A5;
    repeat (100) @(posedge inClock);
    #1;
    checks++;
    if ({bd.displayEn, bd.hSync, bd.vSync, bd.frameStart, bd.rgbOut} !== {e_ctl[3:1], 1'b0, e_rgb}
        || bd.reqX !== 10'(mx[0]) || bd.reqY !== 10'(my[0])) begin
      errors++;
      $display("FAIL pause got ctl=%b%b%b%b rgb=%h req=(%0d,%0d) want %b0 %h (%0d,%0d)",
               bd.displayEn, bd.hSync, bd.vSync, bd.frameStart, bd.rgbOut, bd.reqX, bd.reqY,
               e_ctl[3:1], e_rgb, mx[0], my[0]);
    end
  endtask

  task automatic test_frame;
    int fs_idx[$];
    int vs_low, vs_bad;
    vs_low = 0;
    vs_bad = 0;
    for (int i = 0; i < 460; i++) begin
      strobe(1, 12'($urandom));
      if (ob_ctl[0]) fs_idx.push_back(i);
      if (!ob_ctl[1]) begin
        vs_low++;
        if (ob_y != 7 && ob_y != 8) vs_bad++;
      end
    end
    strobe(1, 12'($urandom));
    if (ob_ctl[0]) fs_idx.push_back(460);
    checks++;
    if (fs_idx.size() != 3 || fs_idx[0] != 0 || fs_idx[1] != 230 || fs_idx[2] != 460) begin
      errors++;
      $display("FAIL frame_spacing got %0d pulses first gap %0d want 3 pulses gap 230", fs_idx.size(),
               fs_idx.size() > 1 ? fs_idx[1] - fs_idx[0] : -1);
    end
    checks++;
    if (vs_low != 92 || vs_bad != 0) begin
      errors++;
      $display("FAIL frame_vsync got low=%0d off_lines=%0d want 92 0", vs_low, vs_bad);
    end
  endtask

  task automatic test_mid_reset;
    while (!(mx[1] == 5 && my[1] == 3)) strobe(1, 12'($urandom));
    strobe(1, 12'($urandom));
    @(posedge inClock);
    #2;
    reset = 1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge inClock);
    reset = 0;
    mx = '{0, 0};
    my = '{0, 0};
    strobe(1, 12'($urandom));
    checks++;
    if (ob_ctl[0] !== 1'b1 || bs.reqX !== 10'd1 || bs.reqY !== 10'd0) begin
      errors++;
      $display("FAIL restart got fs=%b req=(%0d,%0d) want 1 (1,0)", ob_ctl[0], bs.reqX, bs.reqY);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern;
    logic [11:0] c0, c80, c639;
    while (mx[0] != 0) strobe(0, 12'($urandom));
    pat = 1;
    bd.patSel = 1;
    do begin
      strobe(0, 12'($urandom));
      if (ob_x == 0) c0 = ob_rgb;
      if (ob_x == 80) c80 = ob_rgb;
      if (ob_x == 639) c639 = ob_rgb;
    end while (mx[0] != 0);
    checks++;
    if ({c0, c80, c639} !== {12'hFFF, 12'hFF0, 12'h000}) begin
      errors++;
      $display("FAIL pattern got %h %h %h want FFF FF0 000", c0, c80, c639);
    end
    pat = 0;
    bd.patSel = 0;
  endtask
`endif

  initial begin
    bd.pixelEn = 0;
    bd.pixIn = 0;
    bs.pixelEn = 0;
    bs.pixIn = 0;
`ifdef VGA_TEST_PATTERN_EN
    bd.patSel = 0;
    bs.patSel = 0;
`endif
    test_reset();
    test_first_pixel();
    test_line();
    test_const_colour();
    test_pause();
    test_frame();
    test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
